coef_rom_mport: RTL and testbench
=================================

# coef_rom_mport

Multi-port, parametrised-latency coefficient ROM holding the fixed 8×8 table of 8-bit DCT cosine coefficients, one 64-bit row per location. It serves NPORTS independent read ports with per-port valid tracking, a global pipeline-enable (stall), and a per-request transpose mode that returns a coefficient column instead of a row. It sits beside the row/column DCT datapaths, so both passes of a 2-D transform can fetch coefficients from one block.

## Interface
- NPORTS, 2, number of independent read ports (1..8)
- LAT, 2, read latency in enabled clock edges, equal to the pipeline stage count (1..8)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  pipeline advance; 0 freezes every stage on all ports
- rd_valid  in  NPORTS  request strobe per port
- rd_addr  in  3*NPORTS  row/column index; port p uses [3p+2:3p]
- rd_transpose  in  NPORTS  per-request mode: 0 = row, 1 = column
- dout  out  64*NPORTS  read data; port p on [64p+63:64p]
- dout_valid  out  NPORTS  dout slice p carries a result

## Operation
- ROM contents, row r = 0..7, hex:
  - 5B5B5B5B5B5B5B5B
  - 7E6A4719E7B99682
  - 7631CF8A8ACF3176
  - 6AE782B9477E1996
  - 5BA5A55B5BA5A55B
  - 4782196A96E77EB9
  - 318A76CFCF768A31
  - 19B96A827E9647E7
- Byte numbering: byte 0 = bits [63:56], byte 7 = bits [7:0].
- Row mode, addr a: result = row a.
- Column mode, addr c: result byte r = byte c of row r, for r = 0..7. Row 0's byte is in [63:56].
- Lookup is combinational from rd_addr and rd_transpose, then passes through LAT register stages per port.
- Data and valid shift together. Data stages capture every enabled edge regardless of rd_valid.
- dout is meaningful only while dout_valid = 1. The bench must not check it otherwise.
- Ports are fully independent. The same address on several ports in the same cycle is legal, and each port gets its own result.
- No back-pressure output. The block never drops or reorders requests. Per port, order out equals order in.

## Timing
- Reset: on a rising edge with rst = 1, every stage's data and valid clear to 0. Next cycle, dout = 0 and dout_valid = 0 on all ports.
- rst takes priority over en. Requests in flight at reset are discarded, with no partial output.
- Request sampled on an edge with en = 1 appears on dout/dout_valid after the LAT-th enabled edge, counting the sampling edge.
  - With en held high: request before edge N, result visible in the cycle after edge N+LAT-1.
- en = 0 on an edge:
  - No stage loads.
  - Inputs are ignored; a request presented only during a stall is lost.
  - Outputs hold their values.
- Throughput: one request per port per enabled cycle; back-to-back requests are allowed.
- LAT = 1: a single register after the lookup.

## Test plan
- Reset then idle: assert rst for 2 cycles with en = 1 and random inputs. Required: dout = 0 and dout_valid = 0 on all ports, held until the first request emerges.
- Row sweep, LAT = 2, NPORTS = 2, en = 1:
  - Stimulus: port 0 addr 0..7 back-to-back, port 1 addr 7..0, transpose = 0.
  - Required: port 0 shows row 0 (5B5B5B5B5B5B5B5B) two edges after the first request, then the rows in order, one per cycle.
  - Required: port 1 shows row 7 (19B96A827E9647E7) first.
- Column mode:
  - Stimulus: port 0 addr 0 with transpose = 1, and port 1 addr 7 with transpose = 1, in the same cycle.
  - Required: port 0 dout = 5B7E766A5B473119 and port 1 dout = 5B8276965BB931E7, both with dout_valid = 1 on the same cycle.
- Stall:
  - Stimulus: issue addr 3 (row), drop en for 3 cycles after the sampling edge, then raise it.
  - Required: outputs frozen during the stall. Result 6AE782B9477E1996 appears after the second enabled edge. A request applied only while en = 0 never produces dout_valid.
- Reset mid-flight, LAT = 4:
  - Stimulus: issue 3 valid requests on consecutive cycles, then assert rst one cycle later.
  - Required: no dout_valid pulse for any of them. The first post-reset request returns after exactly 4 enabled edges.
- Parameter sweep: NPORTS ∈ {1, 3}, LAT ∈ {1, 5}, random addr/mode/valid/en over 2000 cycles. Required: scoreboard match on every dout_valid, order preserved per port.

Source files
------------

// File: rtl/coef_rom_mport.sv
// coef_rom_mport
//   Multi-port coefficient ROM for the row/column DCT datapaths. It holds the
//   fixed 8x8 table of 8-bit DCT cosine coefficients, one 64-bit row per
//   location. Each port can fetch either a row or a column, so both passes
//   of a 2-D transform can use the same block.
//
//   The lookup is combinational. Its result then runs through LAT register
//   stages per port. Valid and data move through these stages together. A
//   global enable freezes every stage on every port.
//
// Parameters
//   NPORTS        number of independent read ports (1..8)
//   LAT           read latency in enabled clock edges (1..8)
// Ports
//   clk           clock; all logic is on the rising edge
//   rst           synchronous, active-high reset; takes priority over en
//   en            pipeline advance; 0 holds every stage
//   rd_valid      per-port request strobe
//   rd_addr       per-port row/column index; port p uses [3p+2:3p]
//   rd_transpose  per-port mode: 0 = row, 1 = column
//   dout          per-port read data; port p uses [64p+63:64p]
//   dout_valid    per-port flag: the matching dout slice holds a result
module coef_rom_mport #(
  parameter int NPORTS = 2,
  parameter int LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NPORTS-1:0]     rd_valid,
  input  logic [3*NPORTS-1:0]   rd_addr,
  input  logic [NPORTS-1:0]     rd_transpose,
  output logic [64*NPORTS-1:0]  dout,
  output logic [NPORTS-1:0]     dout_valid
);

  // Row r of the coefficient table. Byte 0 of a row is bits [63:56].
  localparam logic [63:0] ROW_ROM [8] = '{
    64'h5B5B5B5B5B5B5B5B,
    64'h7E6A4719E7B99682,
    64'h7631CF8A8ACF3176,
    64'h6AE782B9477E1996,
    64'h5BA5A55B5BA5A55B,
    64'h4782196A96E77EB9,
    64'h318A76CFCF768A31,
    64'h19B96A827E9647E7
  };

  // Column c of the table: byte r of the result is byte c of row r. Row 0
  // goes into the top byte. This reduces to a fixed byte mux per output byte.
  function automatic logic [63:0] col_word(input logic [2:0] c);
    logic [63:0] w;
    w = '0;
    for (int r = 0; r < 8; r++) begin
      w[8*(7-r) +: 8] = ROW_ROM[r][8*(7-int'(c)) +: 8];
    end
    return w;
  endfunction

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [2:0]  addr;
      logic [63:0] lookup_data;
      logic [63:0] data_reg [LAT];
      logic [LAT-1:0] valid_reg;

      assign addr = rd_addr[3*gi +: 3];

      always_comb begin
        lookup_data = ROW_ROM[addr];
        if (rd_transpose[gi]) begin
          lookup_data = col_word(addr);
        end
      end

      // Data stages load on every enabled edge, whether or not the request
      // is valid. Only dout_valid says whether the output is meaningful.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < LAT; s++) begin
            data_reg[s]  <= '0;
            valid_reg[s] <= 1'b0;
          end
        end else if (en) begin
          data_reg[0]  <= lookup_data;
          valid_reg[0] <= rd_valid[gi];
          for (int s = 1; s < LAT; s++) begin
            data_reg[s]  <= data_reg[s-1];
            valid_reg[s] <= valid_reg[s-1];
          end
        end
      end

      assign dout[64*gi +: 64] = data_reg[LAT-1];
      assign dout_valid[gi]    = valid_reg[LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_coef_rom_mport.sv
// tb_coef_rom_mport
//   Runs four configurations of coef_rom_mport in parallel on shared
//   stimulus: (NPORTS,LAT) = (2,2), (2,4), (3,5), (1,1).
//   The bench computes the expected word for each accepted request. It
//   queues that word per port, together with the enabled-edge count at which
//   the word must be visible. Every falling edge it checks dout_valid and
//   dout against the head of each queue.
module tb_coef_rom_mport;

  localparam int NCFG = 4;
  localparam int NP_T  [NCFG] = '{2, 2, 3, 1};
  localparam int LAT_T [NCFG] = '{2, 4, 5, 1};

  localparam logic [63:0] ROW_T [8] = '{
    64'h5B5B5B5B5B5B5B5B, 64'h7E6A4719E7B99682,
    64'h7631CF8A8ACF3176, 64'h6AE782B9477E1996,
    64'h5BA5A55B5BA5A55B, 64'h4782196A96E77EB9,
    64'h318A76CFCF768A31, 64'h19B96A827E9647E7
  };

  typedef struct packed {
    logic [31:0] due;
    logic [63:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] rd_valid;
  logic [8:0] rd_addr;
  logic [2:0] rd_tr;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] a, input logic t);
    logic [63:0] w;
    logic [63:0] row;
    if (!t) return ROW_T[a];
    w = '0;
    for (int r = 0; r < 8; r++) begin
      row = ROW_T[r];
      // byte a of row r (byte 0 = MSB) goes into byte r of the result
      w[63-8*r -: 8] = row[63-8*int'(a) -: 8];
    end
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int NP = NP_T[gi];
      localparam int LT = LAT_T[gi];

      logic [64*NP-1:0] dout;
      logic [NP-1:0]    dout_valid;
      exp_t             q [NP][$];
      int               en_cnt    = 0;
      int               since_rst = 0;
      bit               started   = 1'b0;

      coef_rom_mport #(.NPORTS(NP), .LAT(LT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .rd_valid     (rd_valid[NP-1:0]),
        .rd_addr      (rd_addr[3*NP-1:0]),
        .rd_transpose (rd_tr[NP-1:0]),
        .dout         (dout),
        .dout_valid   (dout_valid)
      );

      // A request sampled on enabled edge k (count k after that edge) must be
      // visible while en_cnt == k+LT-1. That is en_cnt(before) + LT.
      always @(posedge clk) begin
        if (rst) begin
          started   <= 1'b1;
          since_rst <= 0;
          for (int p = 0; p < NP; p++) q[p].delete();
        end else if (en) begin
          en_cnt <= en_cnt + 1;
          if (since_rst < LT) since_rst <= since_rst + 1;
          for (int p = 0; p < NP; p++) begin
            if (rd_valid[p])
              q[p].push_back('{due: 32'(en_cnt + LT),
                               data: model(rd_addr[3*p +: 3], rd_tr[p])});
          end
        end
      end

      always @(negedge clk) begin
        if (started) begin
          for (int p = 0; p < NP; p++) begin
            while (q[p].size() > 0 && q[p][0].due < 32'(en_cnt))
              void'(q[p].pop_front());
            check_val($sformatf("cfg%0d.p%0d valid", gi, p),
                      64'(dout_valid[p]),
                      64'(q[p].size() > 0 && q[p][0].due == 32'(en_cnt)));
            if (q[p].size() > 0 && q[p][0].due == 32'(en_cnt))
              check_val($sformatf("cfg%0d.p%0d data", gi, p),
                        dout[64*p +: 64], q[p][0].data);
            else if (since_rst < LT)
              check_val($sformatf("cfg%0d.p%0d rstzero", gi, p),
                        dout[64*p +: 64], 64'h0);
          end
        end
      end
    end
  endgenerate

  task automatic idle_req();
    rd_valid = '0;
    rd_addr  = '0;
    rd_tr    = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    rd_valid = 3'($urandom);
    rd_addr  = 9'($urandom);
    rd_tr    = 3'($urandom);
    // reset for two cycles with random inputs, then idle
    cycles(1);
    rd_valid = 3'($urandom);
    rd_addr  = 9'($urandom);
    cycles(1);
    rst = 1'b0;
    idle_req();
    cycles(6);

    // row sweep: port 0 up, port 1 down, port 2 idle
    for (int i = 0; i < 8; i++) begin
      rd_valid = 3'b011;
      rd_addr  = {3'd0, 3'(7 - i), 3'(i)};
      rd_tr    = '0;
      cycles(1);
    end
    idle_req();
    cycles(8);

    // column mode, both ports in the same cycle
    rd_valid = 3'b011;
    rd_addr  = {3'd0, 3'd7, 3'd0};
    rd_tr    = 3'b011;
    cycles(1);
    idle_req();
    cycles(8);

    // stall: row 3 sampled, then en low for 3 cycles; request during stall is lost
    rd_valid = 3'b001;
    rd_addr  = {3'd0, 3'd0, 3'd3};
    cycles(1);
    idle_req();
    en = 1'b0;
    cycles(1);
    rd_valid = 3'b010;
    rd_addr  = {3'd0, 3'd5, 3'd0};
    cycles(1);
    idle_req();
    cycles(1);
    en = 1'b1;
    cycles(8);

    // reset mid-flight: three requests, then reset, then one request
    for (int i = 0; i < 3; i++) begin
      rd_valid = 3'b111;
      rd_addr  = {3'(i + 2), 3'(i + 1), 3'(i)};
      rd_tr    = 3'(i);
      cycles(1);
    end
    idle_req();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    rd_valid = 3'b111;
    rd_addr  = {3'd6, 3'd5, 3'd4};
    rd_tr    = 3'b101;
    cycles(1);
    idle_req();
    cycles(8);

    // random traffic with random stalls and occasional resets
    for (int c = 0; c < 2000; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 299) == 0);
      rd_valid = 3'($urandom);
      rd_addr  = 9'($urandom);
      rd_tr    = 3'($urandom);
      cycles(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    idle_req();
    cycles(12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
